// File: rtl/axi_stream_write_fifo_pkg.sv
// Beat layout shared by the AXI-Stream write/read FIFOs.
// A packed beat is {data | keep | dest | id | last}, with last in bit 0.
package axi_stream_write_fifo_pkg;

  localparam int LAST_OFS = 0;
  localparam int ID_OFS   = 1;

  function automatic int keep_width(input int bus_width);
    return bus_width / 8;
  endfunction

  function automatic int dest_ofs(input int id_width);
    return ID_OFS + id_width;
  endfunction

  function automatic int keep_ofs(input int id_width, input int dest_width);
    return dest_ofs(id_width) + dest_width;
  endfunction

  function automatic int data_ofs(input int id_width, input int dest_width, input int bus_width);
    return keep_ofs(id_width, dest_width) + keep_width(bus_width);
  endfunction

  function automatic int beat_width(input int bus_width, input int dest_width, input int id_width);
    return data_ofs(id_width, dest_width, bus_width) + bus_width;
  endfunction

endpackage

// File: rtl/axi_stream_write_fifo_sync_fifo_regs.sv
// Register-array FIFO with push/pop/count. Pointers wrap modulo DEPTH.
// Full and empty are told apart by the count, never by pointer equality.
module sync_fifo_regs #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_aresetn,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [WIDTH-1:0]     i_data,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/axi_stream_write_fifo.sv
// Buffered AXI-Stream master: queue of up to DEPTH beats, the head held in a
// registered output stage so the bus sees back-to-back transfers.
module axi_stream_write_fifo
  import axi_stream_write_fifo_pkg::*;
#(
  parameter int BUS_WIDTH  = 64,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_aresetn,
  input  logic [31:0]            i_core_TID,
  input  logic                   i_enable,
  output logic                   o_ready,
  output logic                   o_idle,
  output logic [CNT_WIDTH-1:0]   o_count,
  output logic                   o_overflow,
  input  logic                   i_clr_overflow,
  input  logic [BUS_WIDTH-1:0]   i_data_to_transmit,
  input  logic [BUS_WIDTH/8-1:0] i_tkeep,
  input  logic [31:0]            i_tdest,
  input  logic                   i_tlast,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [BUS_WIDTH-1:0]   o_tdata,
  output logic [BUS_WIDTH/8-1:0] o_tkeep,
  output logic [DEST_WIDTH-1:0]  o_tdest,
  output logic [ID_WIDTH-1:0]    o_tid,
  output logic                   o_tlast
);

  localparam int KEEP_WIDTH = keep_width(BUS_WIDTH);
  localparam int BEAT_WIDTH = beat_width(BUS_WIDTH, DEST_WIDTH, ID_WIDTH);
  localparam int DEST_OFS   = dest_ofs(ID_WIDTH);
  localparam int KEEP_OFS   = keep_ofs(ID_WIDTH, DEST_WIDTH);
  localparam int DATA_OFS   = data_ofs(ID_WIDTH, DEST_WIDTH, BUS_WIDTH);

  logic [BEAT_WIDTH-1:0] in_beat;
  logic [BEAT_WIDTH-1:0] out_beat;
  logic [BEAT_WIDTH-1:0] fifo_head;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  fifo_empty;
  logic                  push;
  logic                  load_out;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  unused_upper;

  assign in_beat = {i_data_to_transmit, i_tkeep, i_tdest[DEST_WIDTH-1:0],
                    i_core_TID[ID_WIDTH-1:0], i_tlast};
  assign unused_upper = ^{i_core_TID, i_tdest};

  // Occupancy is the queued beats plus the one sitting in the output stage.
  assign o_count = fifo_count + CNT_WIDTH'(o_tvalid);
  assign o_ready = (o_count < CNT_WIDTH'(DEPTH));
  assign o_idle  = (o_count == '0);

  assign push     = i_enable && o_ready;
  assign load_out = !o_tvalid || i_tready;
  // An empty queue lets a new beat go straight into a free output stage.
  assign fifo_pop  = load_out && !fifo_empty;
  assign fifo_push = push && !(load_out && fifo_empty);

  sync_fifo_regs #(
    .WIDTH     (BEAT_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_push    (fifo_push),
    .i_pop     (fifo_pop),
    .i_data    (in_beat),
    .o_data    (fifo_head),
    .o_count   (fifo_count),
    .o_empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_tvalid <= 1'b0;
      out_beat <= '0;
    end else if (load_out) begin
      if (!fifo_empty) begin
        o_tvalid <= 1'b1;
        out_beat <= fifo_head;
      end else if (push) begin
        o_tvalid <= 1'b1;
        out_beat <= in_beat;
      end else begin
        o_tvalid <= 1'b0;
      end
    end
  end

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_overflow <= 1'b0;
    end else if (i_enable && !o_ready) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

  assign o_tdata = out_beat[DATA_OFS +: BUS_WIDTH];
  assign o_tkeep = out_beat[KEEP_OFS +: KEEP_WIDTH];
  assign o_tdest = out_beat[DEST_OFS +: DEST_WIDTH];
  assign o_tid   = out_beat[ID_OFS +: ID_WIDTH];
  assign o_tlast = out_beat[LAST_OFS];

endmodule

// File: tb/tb_axi_stream_write_fifo.sv
// Directed bench for axi_stream_write_fifo (BUS_WIDTH=64, DEST/ID=8, DEPTH=4):
// a vector table plus hand-written multi-cycle sequences and a scoreboarded stall run.
module tb_axi_stream_write_fifo;

  logic        i_clk;
  logic        i_aresetn;
  logic [31:0] i_core_TID;
  logic        i_enable;
  logic        o_ready;
  logic        o_idle;
  logic [2:0]  o_count;
  logic        o_overflow;
  logic        i_clr_overflow;
  logic [63:0] i_data_to_transmit;
  logic [7:0]  i_tkeep;
  logic [31:0] i_tdest;
  logic        i_tlast;
  logic        o_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic [7:0]  o_tkeep;
  logic [7:0]  o_tdest;
  logic [7:0]  o_tid;
  logic        o_tlast;

  int n_cmp  = 0;
  int n_fail = 0;

  axi_stream_write_fifo dut (
    .i_clk              (i_clk),
    .i_aresetn          (i_aresetn),
    .i_core_TID         (i_core_TID),
    .i_enable           (i_enable),
    .o_ready            (o_ready),
    .o_idle             (o_idle),
    .o_count            (o_count),
    .o_overflow         (o_overflow),
    .i_clr_overflow     (i_clr_overflow),
    .i_data_to_transmit (i_data_to_transmit),
    .i_tkeep            (i_tkeep),
    .i_tdest            (i_tdest),
    .i_tlast            (i_tlast),
    .o_tvalid           (o_tvalid),
    .i_tready           (i_tready),
    .o_tdata            (o_tdata),
    .o_tkeep            (o_tkeep),
    .o_tdest            (o_tdest),
    .o_tid              (o_tid),
    .o_tlast            (o_tlast)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       en;
    logic       tr;
    logic       clr;
    logic [7:0] din;
    logic       ev;
    logic [7:0] edat;
    logic [2:0] ecnt;
    logic       erdy;
    logic       eov;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input logic [7:0] n);
    return 64'hA5A5_5A5A_0000_0000 | {56'd0, n};
  endfunction

  // Every beat's side fields derive from its tag n; upper tdest/TID bits are junk.
  task automatic drive_beat(input logic [7:0] n);
    i_data_to_transmit = beat_data(n);
    i_tkeep            = n;
    i_tdest            = {24'hDEAD00, n ^ 8'h5A};
    i_core_TID         = {24'hBEEF00, n + 8'd3};
    i_tlast            = n[0];
  endtask

  task automatic check_beat(input string name, input logic [7:0] n);
    logic [7:0] exp_dest;
    logic [7:0] exp_id;
    exp_dest = n ^ 8'h5A;
    exp_id   = n + 8'd3;
    check({name, "_valid"}, 64'(o_tvalid), 64'd1);
    check({name, "_data"},  o_tdata, beat_data(n));
    check({name, "_keep"},  64'(o_tkeep), 64'(n));
    check({name, "_dest"},  64'(o_tdest), 64'(exp_dest));
    check({name, "_id"},    64'(o_tid), 64'(exp_id));
    check({name, "_last"},  64'(o_tlast), 64'(n[0]));
  endtask

  function automatic vec_t mk(input logic en, input logic tr, input logic clr, input logic [7:0] din,
                              input logic ev, input logic [7:0] edat, input logic [2:0] ecnt,
                              input logic erdy, input logic eov);
    vec_t v;
    v.en = en; v.tr = tr; v.clr = clr; v.din = din;
    v.ev = ev; v.edat = edat; v.ecnt = ecnt; v.erdy = erdy; v.eov = eov;
    return v;
  endfunction

  initial begin : main
    logic [63:0] q[$];
    logic [63:0] held;
    logic        hold_pending;
    logic [63:0] exp_front;
    logic [7:0]  tag;

    i_aresetn      = 1'b0;
    i_enable       = 1'b0;
    i_tready       = 1'b0;
    i_clr_overflow = 1'b0;
    drive_beat(8'd0);
    #12;
    check("rst_valid", 64'(o_tvalid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_ovf",   64'(o_overflow), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_idle",  64'(o_idle), 64'd1);
    check("rst_tdata", o_tdata, 64'd0);
    check("rst_side",  64'({o_tkeep, o_tdest, o_tid, o_tlast}), 64'd0);
    @(negedge i_clk);
    i_aresetn = 1'b1;
    step();

    //                en  tr  clr din    ev  edat  cnt rdy ov
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'd10, 1'b1, 8'd10, 3'd1, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'd11, 1'b1, 8'd10, 3'd2, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'd12, 1'b1, 8'd10, 3'd3, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 8'd13, 1'b1, 8'd10, 3'd4, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'd14, 1'b1, 8'd10, 3'd4, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 8'd15, 1'b1, 8'd11, 3'd3, 1'b1, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 8'd16, 1'b1, 8'd12, 3'd3, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd13, 3'd2, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd16, 3'd1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 8'd0,  3'd0, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 8'd20, 1'b1, 8'd20, 3'd1, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 8'd21, 1'b1, 8'd21, 3'd1, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 8'd22, 1'b1, 8'd22, 3'd1, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd22, 3'd1, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 8'd23, 1'b1, 8'd22, 3'd2, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 8'd24, 1'b1, 8'd22, 3'd3, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 8'd25, 1'b1, 8'd22, 3'd4, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 8'd26, 1'b1, 8'd22, 3'd4, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 8'd22, 3'd4, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd23, 3'd3, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd24, 3'd2, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd25, 3'd1, 1'b1, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 8'd0,  3'd0, 1'b1, 1'b0);

    for (int i = 0; i < 23; i++) begin
      i_enable       = tbl[i].en;
      i_tready       = tbl[i].tr;
      i_clr_overflow = tbl[i].clr;
      drive_beat(tbl[i].din);
      step();
      check($sformatf("vec%0d_valid", i), 64'(o_tvalid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_count", i), 64'(o_count), 64'(tbl[i].ecnt));
      check($sformatf("vec%0d_ready", i), 64'(o_ready), 64'(tbl[i].erdy));
      check($sformatf("vec%0d_idle", i),  64'(o_idle), 64'(tbl[i].ecnt == 3'd0));
      check($sformatf("vec%0d_ovf", i),   64'(o_overflow), 64'(tbl[i].eov));
      if (tbl[i].ev) check_beat($sformatf("vec%0d", i), tbl[i].edat);
    end
    i_clr_overflow = 1'b0;

    // Single beat, zero-bubble latency.
    i_tready           = 1'b1;
    i_enable           = 1'b1;
    i_data_to_transmit = 64'hA5A5_0001;
    i_tkeep            = 8'hFF;
    i_tdest            = 32'd3;
    i_core_TID         = 32'd7;
    i_tlast            = 1'b1;
    step();
    i_enable = 1'b0;
    check("single_valid", 64'(o_tvalid), 64'd1);
    check("single_data",  o_tdata, 64'hA5A5_0001);
    check("single_keep",  64'(o_tkeep), 64'hFF);
    check("single_dest",  64'(o_tdest), 64'd3);
    check("single_id",    64'(o_tid), 64'd7);
    check("single_last",  64'(o_tlast), 64'd1);
    step();
    check("single_count", 64'(o_count), 64'd0);
    check("single_idle",  64'(o_idle), 64'd1);
    check("single_done",  64'(o_tvalid), 64'd0);

    // Back-to-back: 16 beats with no bubbles.
    i_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_enable = 1'b1;
      drive_beat(8'(i));
      step();
      check_beat($sformatf("b2b%0d", i), 8'(i));
      check($sformatf("b2b%0d_ready", i), 64'(o_ready), 64'd1);
    end
    i_enable = 1'b0;
    step();
    check("b2b_drained", 64'(o_count), 64'd0);

    // Asynchronous reset mid-stream with three beats held.
    i_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_enable = 1'b1;
      drive_beat(8'(40 + i));
      step();
    end
    i_enable = 1'b0;
    check("pre_rst_count", 64'(o_count), 64'd3);
    check("pre_rst_valid", 64'(o_tvalid), 64'd1);
    #1;
    i_aresetn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_tvalid), 64'd0);
    check("mid_rst_count", 64'(o_count), 64'd0);
    check("mid_rst_ovf",   64'(o_overflow), 64'd0);
    #2;
    i_aresetn = 1'b1;
    i_enable  = 1'b1;
    drive_beat(8'h77);
    step();
    i_enable = 1'b0;
    check_beat("post_rst", 8'h77);
    check("post_rst_count", 64'(o_count), 64'd1);
    i_tready = 1'b1;
    step();
    check("post_rst_drain", 64'(o_count), 64'd0);

    // Random stalls against random pushes, scoreboarded.
    hold_pending = 1'b0;
    held         = '0;
    tag          = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      if (o_tvalid && hold_pending) check("stall_stable", o_tdata, held);
      i_tready = ($urandom_range(0, 2) != 0);
      i_enable = ($urandom_range(0, 1) == 1) && o_ready;
      drive_beat(tag);
      if (o_tvalid && i_tready) begin
        if (q.size() == 0) begin
          check("rand_unexpected_beat", o_tdata, 64'd0);
        end else begin
          exp_front = q.pop_front();
          check("rand_order", o_tdata, exp_front);
        end
        hold_pending = 1'b0;
      end else if (o_tvalid) begin
        held         = o_tdata;
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
      end
      if (i_enable) begin
        q.push_back(beat_data(tag));
        tag = tag + 8'd1;
      end
      step();
      check("rand_count", 64'(o_count), 64'(q.size()));
    end
    i_enable = 1'b0;
    i_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (o_tvalid) begin
        if (q.size() == 0) begin
          check("drain_unexpected_beat", o_tdata, 64'd0);
        end else begin
          exp_front = q.pop_front();
          check("drain_order", o_tdata, exp_front);
        end
      end
      step();
    end
    check("rand_leftover", 64'(q.size()), 64'd0);
    check("rand_ovf", 64'(o_overflow), 64'd0);
    check("rand_idle", 64'(o_idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
